// File: rtl/onehot_stream_decoder.sv
// Buffers binary codes behind a valid/ready FIFO and presents each one as a
// one-hot word for a fixed number of cycles, with no gap between words.
module onehot_stream_decoder #(
  parameter  int unsigned IN_W        = 2,
  localparam int unsigned OUT_W       = 2 ** IN_W,
  parameter  int unsigned HOLD_CYCLES = 4,
  parameter  int unsigned FIFO_DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [IN_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic [IN_W-1:0]    head_code;
  logic [OUT_W-1:0]   head_onehot;

  // Handshake and FIFO status; in_ready looks only at full, never at a same-cycle pop.
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign busy      = out_valid || !empty;

  // The display slot frees up when idle or on the last cycle of a hold.
  assign slot_free = (state == IDLE) || (hold_cnt == '0);
  assign pop       = slot_free && !empty;

  assign head_code   = mem[rd_ptr];
  assign head_onehot = OUT_W'(1) << head_code;

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Hold FSM: load on pop, count down, reload with no gap or drop back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (!empty) begin
        state     <= HOLD;
        hold_cnt  <= HOLD_RELOAD;
        data_out  <= head_onehot;
        out_valid <= 1'b1;
      end
    end else begin
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else if (!empty) begin
        hold_cnt  <= HOLD_RELOAD;
        data_out  <= head_onehot;
        out_valid <= 1'b1;
      end else begin
        state     <= IDLE;
        data_out  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// Directed bench for onehot_stream_decoder: default instance plus a
// HOLD_CYCLES=1 instance, with hand-computed cycle-by-cycle expectations.
module tb_onehot_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, busy;
  logic [1:0] data_in;
  logic [3:0] data_out;
  logic       in_valid1, in_ready1, out_valid1, busy1;
  logic [1:0] data_in1;
  logic [3:0] data_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_stream_decoder #(.IN_W(2), .HOLD_CYCLES(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .busy(busy)
  );

  onehot_stream_decoder #(.IN_W(2), .HOLD_CYCLES(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_in(data_in1), .data_out(data_out1), .out_valid(out_valid1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; in_valid1 = 1'b0; data_in1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; in_valid1 = 1'b0; data_in1 = '0;
    #1;
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = 2'($urandom_range(0, 3));
      in_valid1 = 1'($urandom_range(0, 1));
      data_in1  = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (data_out !== 4'b0000) begin
        errors++; $display("FAIL reset_data_out cyc %0d: got %b expected 0000", i, data_out);
      end
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        errors++; $display("FAIL reset_flags cyc %0d: {out_valid,in_ready,busy} got %b expected 010", i, {out_valid, in_ready, busy});
      end
      checks++;
      if ({data_out1, out_valid1, in_ready1, busy1} !== 7'b0000_010) begin
        errors++; $display("FAIL reset_dut1 cyc %0d: got %b expected 0000010", i, {data_out1, out_valid1, in_ready1, busy1});
      end
    end
    in_valid = 1'b0; in_valid1 = 1'b0;
  endtask

  task automatic test_single_code();
    logic [3:0] exp_d;
    logic       exp_v;
    do_reset();
    in_valid = 1'b1; data_in = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({data_out, out_valid, busy} !== 6'b0000_01) begin
      errors++; $display("FAIL single_after_push: {data_out,out_valid,busy} got %b expected 000001", {data_out, out_valid, busy});
    end
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp_v = (n <= 4);
      exp_d = exp_v ? 4'b0100 : 4'b0000;
      checks++;
      if (data_out !== exp_d) begin
        errors++; $display("FAIL single_data E%0d: got %b expected %b", n, data_out, exp_d);
      end
      checks++;
      if ({out_valid, busy} !== {exp_v, exp_v}) begin
        errors++; $display("FAIL single_valid_busy E%0d: got %b expected %b", n, {out_valid, busy}, {exp_v, exp_v});
      end
    end
  endtask

  task automatic test_back_to_back();
    int          idx;
    logic        acc;
    logic [31:0] acc_mask;
    logic [31:0] exp_mask;
    logic [3:0]  exp_d;
    logic        exp_rdy;
    do_reset();
    idx = 0; acc_mask = '0;
    exp_mask = 32'h0000_008E;
    for (int n = 1; n <= 21; n++) begin
      in_valid = (idx < 4);
      data_in  = 2'(idx);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        acc_mask[n] = 1'b1;
      end
      if (n >= 2 && n <= 5)        exp_d = 4'b0001;
      else if (n >= 6 && n <= 9)   exp_d = 4'b0010;
      else if (n >= 10 && n <= 13) exp_d = 4'b0100;
      else if (n >= 14 && n <= 17) exp_d = 4'b1000;
      else                         exp_d = 4'b0000;
      exp_rdy = !((n >= 3 && n <= 5) || (n >= 7 && n <= 9));
      checks++;
      if (data_out !== exp_d) begin
        errors++; $display("FAIL b2b_data E%0d: got %b expected %b", n, data_out, exp_d);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready E%0d: got %b expected %b", n, in_ready, exp_rdy);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_mask !== exp_mask) begin
      errors++; $display("FAIL b2b_accept_edges: got %h expected %h", acc_mask, exp_mask);
    end
  endtask

  task automatic test_async_reset_mid_hold();
    do_reset();
    in_valid = 1'b1; data_in = 2'd3; tick();
    data_in = 2'd1; tick();
    data_in = 2'd2; tick();
    in_valid = 1'b0;
    checks++;
    if ({data_out, busy, in_ready} !== 6'b1000_10) begin
      errors++; $display("FAIL areset_precondition: {data_out,busy,in_ready} got %b expected 100010", {data_out, busy, in_ready});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, out_valid, busy, in_ready} !== 7'b0000_001) begin
      errors++; $display("FAIL areset_immediate: {data_out,out_valid,busy,in_ready} got %b expected 0000001", {data_out, out_valid, busy, in_ready});
    end
    #2 rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if ({data_out, out_valid, busy} !== 6'b0) begin
        errors++; $display("FAIL areset_no_ghost cyc %0d: {data_out,out_valid,busy} got %b expected 000000", n, {data_out, out_valid, busy});
      end
    end
  endtask

  task automatic test_hold_one();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'b0000; exp_d[1] = 4'b1000; exp_d[2] = 4'b0001; exp_d[3] = 4'b0000;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      in_valid1 = (n < 2);
      data_in1  = (n == 0) ? 2'b11 : 2'b00;
      tick();
      checks++;
      if (data_out1 !== exp_d[n]) begin
        errors++; $display("FAIL hold1_data E%0d: got %b expected %b", n, data_out1, exp_d[n]);
      end
      checks++;
      if (out_valid1 !== (n == 1 || n == 2)) begin
        errors++; $display("FAIL hold1_valid E%0d: got %b expected %b", n, out_valid1, (n == 1 || n == 2));
      end
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    logic [3:0] exp_d;
    // count==1 at expiry: push and pop together, C follows B with no gap
    do_reset();
    in_valid = 1'b1; data_in = 2'd1; tick();
    data_in = 2'd2; tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (data_out !== 4'b0010) begin
      errors++; $display("FAIL spp1_before_expiry: got %b expected 0010", data_out);
    end
    in_valid = 1'b1; data_in = 2'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({data_out, out_valid, in_ready} !== 6'b0100_11) begin
      errors++; $display("FAIL spp1_expiry: {data_out,out_valid,in_ready} got %b expected 010011", {data_out, out_valid, in_ready});
    end
    for (int n = 6; n <= 14; n++) begin
      tick();
      if (n <= 8)       exp_d = 4'b0100;
      else if (n <= 12) exp_d = 4'b1000;
      else              exp_d = 4'b0000;
      checks++;
      if (data_out !== exp_d) begin
        errors++; $display("FAIL spp1_data E%0d: got %b expected %b", n, data_out, exp_d);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL spp1_busy_end: got %b expected 0", busy);
    end

    // count==FIFO_DEPTH at expiry: the offered code must not be taken
    do_reset();
    in_valid = 1'b1; data_in = 2'd0; tick();
    data_in = 2'd1; tick();
    data_in = 2'd2; tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({data_out, in_ready} !== 5'b0001_0) begin
      errors++; $display("FAIL spp2_full: {data_out,in_ready} got %b expected 00010", {data_out, in_ready});
    end
    in_valid = 1'b1; data_in = 2'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({data_out, in_ready} !== 5'b0010_1) begin
      errors++; $display("FAIL spp2_expiry: {data_out,in_ready} got %b expected 00101", {data_out, in_ready});
    end
    for (int n = 6; n <= 16; n++) begin
      tick();
      if (n <= 8)       exp_d = 4'b0010;
      else if (n <= 12) exp_d = 4'b0100;
      else              exp_d = 4'b0000;
      checks++;
      if (data_out !== exp_d) begin
        errors++; $display("FAIL spp2_data E%0d: got %b expected %b", n, data_out, exp_d);
      end
    end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL spp2_idle_end: {out_valid,busy} got %b expected 00", {out_valid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single_code();
    test_back_to_back();
    test_async_reset_mid_hold();
    test_hold_one();
    test_simul_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
